// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate helpers used by the sync
// generator and every ROM renderer that consumes pixel_x/pixel_y.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned MAX_X    = 640;
  localparam int unsigned MAX_Y    = 480;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned HS_START = 656;
  localparam int unsigned HS_END   = 751;
  localparam int unsigned VS_START = 490;
  localparam int unsigned VS_END   = 491;

  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV divider producing a one-clock pixel tick; the tick is registered
// so it stays low through reset and on the first clock after release.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic       tick_q;

  always_comb begin
    div_d = (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 4'd0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DivLast);
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster scan generator: pixel tick, x/y scan counters and registered sync /
// video_on decode aligned with the counts they describe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SW     = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SW     = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int unsigned HTotal = H_DISP + H_FP + H_SW + H_BP;
  localparam int unsigned VTotal = V_DISP + V_FP + V_SW + V_BP;

  localparam coord_t HLast   = coord_t'(HTotal - 1);
  localparam coord_t VLast   = coord_t'(VTotal - 1);
  localparam coord_t HDisp   = coord_t'(H_DISP);
  localparam coord_t VDisp   = coord_t'(V_DISP);
  localparam coord_t HsStart = coord_t'(H_DISP + H_FP);
  localparam coord_t HsEnd   = coord_t'(H_DISP + H_FP + H_SW - 1);
  localparam coord_t VsStart = coord_t'(V_DISP + V_FP);
  localparam coord_t VsEnd   = coord_t'(V_DISP + V_FP + V_SW - 1);

  if (HTotal > 1024 || VTotal > 1024) begin : g_range_err
    $error("vga_sync_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in 10 bits");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_err
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic   tick;
  coord_t x_q, x_d, y_q, y_d;
  logic   x_wrap, frame_wrap;
  logic   hsync_q, vsync_q, video_on_q, frame_start_q;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(tick)
  );

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    x_wrap     = (x_q == HLast);
    frame_wrap = tick && x_wrap && (y_q == VLast);
    if (tick) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decode from next-state counts so outputs line up with the registered x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= in_span(x_d, HsStart, HsEnd) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= in_span(y_d, VsStart, VsEnd) ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= (x_d < HDisp) && (y_d < VDisp);
      frame_start_q <= frame_wrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign p_tick      = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign frame_start = frame_start_q;

endmodule
